dkgp8_arb: RTL and testbench

- Registered, multi-requester front end for the 8-bit reversible ALU `dkgp8`. The ALU is combinational: A, B, SEL[2:0] in; RESULT[7:0], COUT out.
- Arbitrates NREQ requesters with round-robin priority and feeds the single `dkgp8` instance one operation at a time.
- Captures RESULT/COUT into a register and returns it to the granted requester over a valid/ready response handshake.
- Sits between requester blocks and the ALU datapath.

---
 rtl/dkgp8_pkg.sv | 21 ++
 rtl/dkgp8_arb_if.sv | 34 +++
 rtl/dkgp8.sv | 23 ++
 rtl/dkgp8_arb_rr_arbiter.sv | 28 ++
 rtl/dkgp8_arb.sv | 113 +++++++++++
 tb/tb_dkgp8_arb.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/dkgp8_pkg.sv
// Shared opcode encodings, arbiter FSM states and opcode helper for the dkgp8 front end.
package dkgp8_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOTA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Encodings 001..011 are unassigned in the ALU opcode space.
    function automatic logic is_reserved_sel(input logic [2:0] sel);
        return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b011);
    endfunction

endpackage

// File: rtl/dkgp8_arb_if.sv
// Requester/response bus of dkgp8_arb; rsp_err exists only with DKGP8_ARB_SELCHK_EN.
interface dkgp8_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_sel;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [7:0]        rsp_result;
    logic              rsp_cout;
    logic              busy;
`ifdef DKGP8_ARB_SELCHK_EN
    logic              rsp_err;
`endif

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, busy
`ifdef DKGP8_ARB_SELCHK_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, busy
`ifdef DKGP8_ARB_SELCHK_EN
        , output rsp_err
`endif
    );
endinterface

// File: rtl/dkgp8.sv
// Combinational 8-bit ALU: ADD/AND/OR/XOR/NOTA; carry is only defined for ADD.
module dkgp8
    import dkgp8_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [2:0] SEL,
    output logic [7:0] RESULT,
    output logic       COUT
);
    always_comb begin
        RESULT = A;
        COUT   = 1'b0;
        case (SEL)
            OP_ADD:  {COUT, RESULT} = {1'b0, A} + {1'b0, B};
            OP_AND:  RESULT = A & B;
            OP_OR:   RESULT = A | B;
            OP_XOR:  RESULT = A ^ B;
            OP_NOTA: RESULT = ~A;
            default: RESULT = A;
        endcase
    end
endmodule

// File: rtl/dkgp8_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/dkgp8_arb.sv
// Round-robin front end serialising NREQ requesters onto one dkgp8 ALU.
// Optional reserved-opcode checking via DKGP8_ARB_SELCHK_EN.
module dkgp8_arb
    import dkgp8_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic        clk,
    input  logic        rst,
    dkgp8_arb_if.slave  bus
);
    state_t           state, state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [NREQ-1:0]  arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [7:0]       op_a, op_b;
    logic [2:0]       op_sel;
    logic [7:0]       alu_result;
    logic             alu_cout;
    logic [7:0]       result_q;
    logic             cout_q;
`ifdef DKGP8_ARB_SELCHK_EN
    logic             err_q;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    dkgp8 u_alu (
        .A      (op_a),
        .B      (op_b),
        .SEL    (op_sel),
        .RESULT (alu_result),
        .COUT   (alu_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready[grant_idx]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state == IDLE) bus.req_ready = arb_grant;
        if (state == RESP) bus.rsp_valid[grant_idx] = 1'b1;
        bus.busy = (state != IDLE);
    end

    // Operand registers carry data only; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && arb_any) begin
            op_a   <= bus.req_a[8*arb_idx +: 8];
            op_b   <= bus.req_b[8*arb_idx +: 8];
            op_sel <= bus.req_sel[3*arb_idx +: 3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            grant_idx <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
`ifdef DKGP8_ARB_SELCHK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            if (state == IDLE && arb_any) grant_idx <= arb_idx;
            if (state == EXEC) begin
                ptr <= IDX_W'((int'(grant_idx) + 1) % NREQ);
`ifdef DKGP8_ARB_SELCHK_EN
                if (is_reserved_sel(op_sel)) begin
                    result_q <= '0;
                    cout_q   <= 1'b0;
                    err_q    <= 1'b1;
                end else begin
                    result_q <= alu_result;
                    cout_q   <= alu_cout;
                    err_q    <= 1'b0;
                end
`else
                result_q <= alu_result;
                cout_q   <= alu_cout;
`endif
            end
        end
    end

    assign bus.rsp_result = result_q;
    assign bus.rsp_cout   = cout_q;
`ifdef DKGP8_ARB_SELCHK_EN
    assign bus.rsp_err    = err_q;
`endif
endmodule

// File: tb/tb_dkgp8_arb.sv
// Scoreboard bench for dkgp8_arb with two requesters; define DKGP8_ARB_SELCHK_EN for the opcode-check cases.
module tb_dkgp8_arb;
    localparam int NREQ = 2;

    typedef struct {
        int         idx;
        logic [7:0] res;
        logic       cout;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    dkgp8_arb_if #(.NREQ(NREQ)) bus ();

    dkgp8_arb #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] res, input logic cout, input logic err);
        exp_t e;
        e.idx = idx; e.res = res; e.cout = cout; e.err = err;
        q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        bus.req_a[8*i +: 8]   = a;
        bus.req_b[8*i +: 8]   = b;
        bus.req_sel[3*i +: 3] = sel;
        bus.req_valid[i]      = 1'b1;
    endtask

    // Returns at accept edge + 1 time unit with the request withdrawn.
    task automatic wait_accept(input int i);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.req_ready[i]) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL accept_timeout: requester %0d never got req_ready", i);
        end
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every completed response handshake is matched against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: idx %0d result 0x%0h with empty scoreboard", i, bus.rsp_result);
                    end else begin
                        exp_t e;
                        logic [NREQ-1:0] ev;
                        e  = q.pop_front();
                        ev = NREQ'(1) << e.idx;
                        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
                        chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                        chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
`ifdef DKGP8_ARB_SELCHK_EN
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
                    end
                end
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = '1;
        cycles(2);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_result", 32'(bus.rsp_result), 0);
        chk("rst_cout", 32'(bus.rsp_cout), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD 13+3 on requester 0, with latency and busy checks.
        set_req(0, 8'd13, 8'd3, 3'b000);
        push(0, 8'd16, 1'b0, 1'b0);
        wait_accept(0);
        @(negedge clk);
        chk("exec_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("exec_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("lat_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;

        // ADD 255+1 on requester 1: wraps with carry.
        set_req(1, 8'd255, 8'd1, 3'b000);
        push(1, 8'd0, 1'b1, 1'b0);
        wait_accept(1);
        cycles(3);

        // Reset, then simultaneous requests: index 0 first, then 1, then 0 again.
        rst = 1'b1; cycles(1); rst = 1'b0;
        set_req(0, 8'hAA, 8'hCC, 3'b100);
        set_req(1, 8'hAA, 8'hCC, 3'b110);
        push(0, 8'h88, 1'b0, 1'b0);
        push(1, 8'h66, 1'b0, 1'b0);
        wait_accept(0);
        wait_accept(1);
        cycles(3);
        set_req(0, 8'd1, 8'd2, 3'b000);
        set_req(1, 8'd4, 8'd5, 3'b000);
        push(0, 8'd3, 1'b0, 1'b0);
        push(1, 8'd9, 1'b0, 1'b0);
        wait_accept(0);
        wait_accept(1);
        cycles(3);

        // OR with response back-pressure; requester 1 must wait.
        bus.rsp_ready[0] = 1'b0;
        set_req(0, 8'hAA, 8'hCC, 3'b101);
        set_req(1, 8'd7, 8'd8, 3'b000);
        push(0, 8'hEE, 1'b0, 1'b0);
        push(1, 8'd15, 1'b0, 1'b0);
        wait_accept(0);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("stall_result", 32'(bus.rsp_result), 32'hEE);
            chk("stall_req_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready[0] = 1'b1;
        wait_accept(1);
        cycles(3);

        // Move the pointer to 1, then reset during EXEC of a NOTA.
        set_req(0, 8'd1, 8'd1, 3'b000);
        push(0, 8'd2, 1'b0, 1'b0);
        wait_accept(0);
        cycles(3);
        set_req(1, 8'hAA, 8'h00, 3'b111);
        wait_accept(1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_result", 32'(bus.rsp_result), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(bus.rsp_valid), 0);
        end
        @(posedge clk); #1;
        set_req(0, 8'hAA, 8'h00, 3'b111);
        set_req(1, 8'd2, 8'd2, 3'b000);
        push(0, 8'h55, 1'b0, 1'b0);
        push(1, 8'd4, 1'b0, 1'b0);
        wait_accept(0);
        wait_accept(1);
        cycles(3);

`ifdef DKGP8_ARB_SELCHK_EN
        set_req(0, 8'd13, 8'd3, 3'b010);
        push(0, 8'd0, 1'b0, 1'b1);
        wait_accept(0);
        cycles(3);
        set_req(0, 8'd13, 8'd3, 3'b000);
        push(0, 8'd16, 1'b0, 1'b0);
        wait_accept(0);
        cycles(3);
`endif

        for (int n = 0; n < 20 && q.size() != 0; n++) cycles(1);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
